// File: rtl/dmem_stream_pkg.sv
// Shared constants, FSM state and tagged-word layout for the data-memory streamer.
package dmem_stream_pkg;

   localparam int DEPTH   = 112;
   localparam int ROW_LEN = 16;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 9;
   localparam int COL_W   = $clog2(ROW_LEN);
   localparam int ROW_W   = ADDR_W - COL_W;
   localparam int TAG_W   = 2 + ROW_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic              frame_last;
      logic              row_last;
      logic [ROW_W-1:0]  row_idx;
      logic [DATA_W-1:0] data;
   } tword_t;

   localparam int TWORD_W = $bits(tword_t);

   // Tag bits {frame_last, row_last, row_idx} for a memory address.
   function automatic logic [TAG_W-1:0] addr_tags(input logic [ADDR_W-1:0] addr);
      logic             fl;
      logic             rl;
      logic [ROW_W-1:0] ri;
      fl = (addr == ADDR_W'(DEPTH - 1));
      rl = (addr[COL_W-1:0] == COL_W'(ROW_LEN - 1));
      ri = addr[ADDR_W-1:COL_W];
      return {fl, rl, ri};
   endfunction

endpackage

// File: rtl/dmem_stream_fifo.sv
// Small synchronous FIFO with flush, exposing head and occupancy, plus its checker.
module stream_fifo #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy update; flush wins over push and pop.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
         if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

   stream_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .count (count_r)
   );

endmodule

module stream_fifo_chk #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input logic          clk,
   input logic          rst,
   input logic          flush,
   input logic          push,
   input logic          pop,
   input logic [CW-1:0] count
);

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst || flush)
      !(push && !pop && count == CW'(DEPTH)))
      else $error("stream_fifo overflow");

   a_no_underflow: assert property (@(posedge clk) disable iff (!rst || flush)
      !(pop && count == CW'(0)))
      else $error("stream_fifo underflow");

endmodule

// File: rtl/dmem_stream.sv
// Streams one frame of the data memory (1-cycle read latency) onto a valid/ready port
// with row/frame tags; optional abort input under `DMEM_STREAM_ABORT_EN.
module dmem_stream
   import dmem_stream_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
`ifdef DMEM_STREAM_ABORT_EN
   input  logic              abort,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_row_last,
   output logic              out_frame_last,
   output logic [ROW_W-1:0]  out_row_idx
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   state_t            state_r, state_nxt_s;
   logic [ADDR_W:0]   rd_ptr_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic              iss1_r, iss2_r;
   logic [TAG_W-1:0]  tag2_r;
   logic              done_r;
   logic [CW-1:0]     fifo_count_s;
   logic [CW:0]       used_s;
   tword_t            head_s;
   logic              abort_s, start_s, issue_s, can_issue_s;
   logic              out_valid_s, pop_s, push_s, last_pop_s;

`ifdef DMEM_STREAM_ABORT_EN
   assign abort_s = abort & (state_r != IDLE);
`else
   assign abort_s = 1'b0;
`endif

   // Credits: words queued plus words still in the memory pipeline.
   assign used_s      = (CW+1)'(fifo_count_s) + (CW+1)'(iss1_r) + (CW+1)'(iss2_r);
   assign can_issue_s = (used_s < (CW+1)'(FIFO_DEPTH));
   assign out_valid_s = (fifo_count_s != CW'(0));
   assign pop_s       = out_valid_s & out_ready;
   assign push_s      = iss2_r & ~abort_s;
   assign last_pop_s  = pop_s & head_s.frame_last;

   // Next-state and issue decision.
   always_comb begin
      state_nxt_s = state_r;
      start_s     = 1'b0;
      issue_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = RUN;
               start_s     = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (abort_s) begin
               state_nxt_s = IDLE;
            end else if (can_issue_s) begin
               issue_s = 1'b1;
               if (rd_ptr_r == (ADDR_W+1)'(DEPTH - 1)) begin
                  state_nxt_s = DRAIN;
               end else begin
                  state_nxt_s = RUN;
               end
            end else begin
               state_nxt_s = RUN;
            end
         end
         DRAIN: begin
            if (abort_s || last_pop_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state_r <= IDLE;
      else      state_r <= state_nxt_s;
   end

   // Address issue stage; mem_addr holds whenever nothing is issued.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_r   <= {(ADDR_W+1){1'b0}};
         mem_addr_r <= {ADDR_W{1'b0}};
         iss1_r     <= 1'b0;
      end else if (start_s) begin
         rd_ptr_r   <= (ADDR_W+1)'(1);
         mem_addr_r <= {ADDR_W{1'b0}};
         iss1_r     <= 1'b1;
      end else if (issue_s) begin
         rd_ptr_r   <= rd_ptr_r + (ADDR_W+1)'(1);
         mem_addr_r <= rd_ptr_r[ADDR_W-1:0];
         iss1_r     <= 1'b1;
      end else begin
         iss1_r     <= 1'b0;
      end
   end

   // Memory-latency stage: tags travel with the word the memory is reading now.
   always_ff @(posedge clk) begin
      if (!rst) begin
         iss2_r <= 1'b0;
         tag2_r <= {TAG_W{1'b0}};
      end else begin
         iss2_r <= iss1_r & ~abort_s;
         tag2_r <= addr_tags(mem_addr_r);
      end
   end

   // Completion pulse for the cycle after the frame-last handshake.
   always_ff @(posedge clk) begin
      if (!rst) done_r <= 1'b0;
      else      done_r <= last_pop_s & ~abort_s;
   end

   stream_fifo #(.WIDTH(TWORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (abort_s),
      .push      (push_s),
      .push_data ({tag2_r, mem_data}),
      .pop       (pop_s),
      .head      (head_s),
      .count     (fifo_count_s)
   );

   assign busy           = (state_r != IDLE);
   assign done           = done_r;
   assign mem_addr       = mem_addr_r;
   assign out_valid      = out_valid_s;
   assign out_data       = out_valid_s ? head_s.data : {DATA_W{1'b0}};
   assign out_row_last   = out_valid_s & head_s.row_last;
   assign out_frame_last = out_valid_s & head_s.frame_last;
   assign out_row_idx    = out_valid_s ? head_s.row_idx : {ROW_W{1'b0}};

endmodule
